formant_dp_sequencer: RTL

//  Top-level scheduler for the formant DP. Steps column index i from 0 to I-1.
//  For each i it starts the Emin column engine, then the F engine (begin_iter/iter_done).

---
 rtl/formant_dp_sequencer_if.sv | 43 ++++
 rtl/formant_dp_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/formant_dp_sequencer_if.sv
// Control, engine handshake and F/B table write bundle around the formant DP sequencer.
// master = sequencer side, slave = engines/table/host side.
interface formant_dp_sequencer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int FORMANTS  = 5
);
    localparam int IW = $clog2(I);
    localparam int KW = $clog2(FORMANTS);
    localparam int AW = $clog2(FORMANTS * I);

    logic                 start;
    logic                 abort;
    logic                 emin_start;
    logic [IW-1:0]        emin_i;
    logic                 emin_done;
    logic                 f_begin;
    logic [IW-1:0]        f_i;
    logic                 f_valid;
    logic [KW-1:0]        f_k;
    logic [BIT_WIDTH-1:0] f_data;
    logic [BIT_WIDTH-1:0] b_data;
    logic                 f_iter_done;
    logic                 tbl_we;
    logic [AW-1:0]        tbl_addr;
    logic [BIT_WIDTH-1:0] tbl_f;
    logic [BIT_WIDTH-1:0] tbl_b;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        input  start, abort, emin_done, f_valid, f_k, f_data, b_data, f_iter_done,
        output emin_start, emin_i, f_begin, f_i, tbl_we, tbl_addr, tbl_f, tbl_b,
               busy, done, error
    );

    modport slave (
        output start, abort, emin_done, f_valid, f_k, f_data, b_data, f_iter_done,
        input  emin_start, emin_i, f_begin, f_i, tbl_we, tbl_addr, tbl_f, tbl_b,
               busy, done, error
    );
endinterface

// File: rtl/formant_dp_sequencer.sv
// Steps DP columns 0..I-1: Emin engine, then F engine per column, forwarding F/B writes to the table.
// All outputs registered (writes land one cycle after f_valid); a watchdog faults a stalled engine.
module formant_dp_sequencer #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int FORMANTS  = 5,
    parameter int TIMEOUT   = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    formant_dp_sequencer_if.master bus
);
    localparam int IW  = $clog2(I);
    localparam int KW  = $clog2(FORMANTS);
    localparam int AW  = $clog2(FORMANTS * I);
    localparam int WDW = $clog2(TIMEOUT);
    // Write count can never exceed the cycles spent in F_WAIT, which the watchdog bounds.
    localparam int CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE, E_REQ, E_WAIT, F_REQ, F_WAIT, FINISH, FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        i_q, i_d;
    logic [WDW-1:0]       wd_q, wd_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic                 emin_start_q, emin_start_d;
    logic [IW-1:0]        emin_i_q, emin_i_d;
    logic                 f_begin_q, f_begin_d;
    logic [IW-1:0]        f_i_q, f_i_d;
    logic                 tbl_we_q, tbl_we_d;
    logic [AW-1:0]        tbl_addr_q, tbl_addr_d;
    logic [BIT_WIDTH-1:0] tbl_f_q, tbl_f_d;
    logic [BIT_WIDTH-1:0] tbl_b_q, tbl_b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 k_legal;
    logic                 wd_max;
    logic                 last_col;
    logic [31:0]          need;
    logic [CW-1:0]        wcnt_final;

    assign k_legal    = (bus.f_k != '0) && (32'(bus.f_k) <= 32'(FORMANTS));
    assign wd_max     = (wd_q == WDW'(TIMEOUT - 1));
    assign last_col   = (32'(i_q) == 32'(I - 1));
    assign need       = (32'(i_q) + 32'd1 < 32'(FORMANTS)) ? 32'(i_q) + 32'd1 : 32'(FORMANTS);
    // The F engine raises its last f_valid together with iter_done, so that beat counts too.
    assign wcnt_final = wcnt_q + CW'(bus.f_valid);

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        wd_d         = wd_q;
        wcnt_d       = wcnt_q;
        emin_start_d = 1'b0;
        emin_i_d     = emin_i_q;
        f_begin_d    = 1'b0;
        f_i_d        = f_i_q;
        tbl_we_d     = 1'b0;
        tbl_addr_d   = tbl_addr_q;
        tbl_f_d      = tbl_f_q;
        tbl_b_d      = tbl_b_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;

        // A legal write seen in F_WAIT is forwarded even if abort arrives in the same cycle.
        if (state_q == F_WAIT && bus.f_valid && k_legal) begin
            tbl_we_d   = 1'b1;
            tbl_addr_d = AW'(bus.f_k - KW'(1)) * AW'(I) + AW'(i_q);
            tbl_f_d    = bus.f_data;
            tbl_b_d    = bus.b_data;
        end

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, FAULT: begin
                    if (bus.start && !bus.abort) begin
                        state_d = E_REQ;
                        i_d     = '0;
                        busy_d  = 1'b1;
                        error_d = 1'b0;
                    end
                end
                E_REQ: begin
                    emin_start_d = 1'b1;
                    emin_i_d     = i_q;
                    wd_d         = '0;
                    state_d      = E_WAIT;
                end
                E_WAIT: begin
                    if (bus.emin_done) begin
                        state_d = F_REQ;
                    end else if (wd_max) begin
                        state_d = FAULT;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
                F_REQ: begin
                    f_begin_d = 1'b1;
                    f_i_d     = i_q;
                    wcnt_d    = '0;
                    wd_d      = '0;
                    state_d   = F_WAIT;
                end
                F_WAIT: begin
                    wcnt_d = wcnt_final;
                    if (bus.f_valid && !k_legal) begin
                        state_d = FAULT;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else if (bus.f_iter_done) begin
                        if (32'(wcnt_final) != need) begin
                            state_d = FAULT;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                        end else if (last_col) begin
                            state_d = FINISH;
                        end else begin
                            i_d     = i_q + IW'(1);
                            state_d = E_REQ;
                        end
                    end else if (wd_max) begin
                        state_d = FAULT;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            i_q          <= '0;
            wd_q         <= '0;
            wcnt_q       <= '0;
            emin_start_q <= 1'b0;
            emin_i_q     <= '0;
            f_begin_q    <= 1'b0;
            f_i_q        <= '0;
            tbl_we_q     <= 1'b0;
            tbl_addr_q   <= '0;
            tbl_f_q      <= '0;
            tbl_b_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            wd_q         <= wd_d;
            wcnt_q       <= wcnt_d;
            emin_start_q <= emin_start_d;
            emin_i_q     <= emin_i_d;
            f_begin_q    <= f_begin_d;
            f_i_q        <= f_i_d;
            tbl_we_q     <= tbl_we_d;
            tbl_addr_q   <= tbl_addr_d;
            tbl_f_q      <= tbl_f_d;
            tbl_b_q      <= tbl_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.emin_start = emin_start_q;
    assign bus.emin_i     = emin_i_q;
    assign bus.f_begin    = f_begin_q;
    assign bus.f_i        = f_i_q;
    assign bus.tbl_we     = tbl_we_q;
    assign bus.tbl_addr   = tbl_addr_q;
    assign bus.tbl_f      = tbl_f_q;
    assign bus.tbl_b      = tbl_b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule
